// File: rtl/uart_boot_loader.sv
// UART boot loader: assembles little-endian 32-bit words from the RX byte stream
// into instruction memory while holding the CPU in reset, then acknowledges with "R",CR.
module uart_boot_loader #(
    parameter int          ADDR_WIDTH     = 8,
    parameter logic [31:0] STOP_WORD      = 32'hFFFF_FFFF,
    parameter int          TIMEOUT_CYCLES = 2000000
) (
    input  logic                  in_CLK,
    input  logic                  in_RST_N,
    input  logic                  in_FLASH,
    input  logic [7:0]            in_RX_DATA,
    input  logic                  in_RX_VALID,
    output logic [7:0]            out_TX_DATA,
    output logic                  out_TX_VALID,
    input  logic                  in_TX_READY,
    output logic                  out_MEM_WE,
    output logic [ADDR_WIDTH-1:0] out_MEM_ADDR,
    output logic [31:0]           out_MEM_WDATA,
    output logic                  out_CPU_RST,
    output logic                  out_BUSY,
    output logic                  out_DONE,
    output logic                  out_ERROR,
    output logic [ADDR_WIDTH:0]   out_WORD_COUNT
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [ADDR_WIDTH:0] CAP = {1'b1, {ADDR_WIDTH{1'b0}}};

    typedef enum logic [2:0] {IDLE, RECV, ACK_R, ACK_CR, ERR} state_t;

    state_t        state, state_nxt;
    logic          flash_q;
    logic          start;
    logic [1:0]    idx;
    logic [23:0]   asm_q;
    logic [TW-1:0] tmo;
    logic [31:0]   word;
    logic          rx_acc, word_done, is_stop, mem_full, tmo_hit;

    assign start     = in_FLASH & ~flash_q;
    assign rx_acc    = (state == RECV) & in_RX_VALID;
    assign word      = {in_RX_DATA, asm_q};
    assign word_done = rx_acc & (idx == 2'd3);
    assign is_stop   = (word == STOP_WORD);
    assign mem_full  = (out_WORD_COUNT == CAP);
    assign tmo_hit   = (state == RECV) & ~in_RX_VALID & (tmo == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge in_CLK or negedge in_RST_N) begin
        if (!in_RST_N) state <= IDLE;
        else           state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        out_TX_VALID = 1'b0;
        out_TX_DATA  = 8'h00;
        out_BUSY     = (state != IDLE) && (state != ERR);
        case (state)
            RECV: begin
                if (word_done) begin
                    if (is_stop)       state_nxt = ACK_R;
                    else if (mem_full) state_nxt = ERR;
                end else if (tmo_hit) begin
                    state_nxt = ERR;
                end
            end
            ACK_R: begin
                out_TX_VALID = 1'b1;
                out_TX_DATA  = 8'h52;
                if (in_TX_READY) state_nxt = ACK_CR;
            end
            ACK_CR: begin
                out_TX_VALID = 1'b1;
                out_TX_DATA  = 8'h0D;
                if (in_TX_READY) state_nxt = IDLE;
            end
            default: ;
        endcase
        // A flash edge overrides whatever the current state was doing.
        if (start) state_nxt = RECV;
    end

    always_ff @(posedge in_CLK or negedge in_RST_N) begin
        if (!in_RST_N) begin
            flash_q        <= 1'b0;
            idx            <= 2'd0;
            asm_q          <= 24'd0;
            tmo            <= '0;
            out_WORD_COUNT <= '0;
            out_MEM_WE     <= 1'b0;
            out_MEM_ADDR   <= '0;
            out_MEM_WDATA  <= 32'd0;
            out_CPU_RST    <= 1'b0;
            out_DONE       <= 1'b0;
            out_ERROR      <= 1'b0;
        end else begin
            flash_q    <= in_FLASH;
            out_MEM_WE <= 1'b0;
            out_DONE   <= 1'b0;
            if (start) begin
                idx            <= 2'd0;
                tmo            <= '0;
                out_WORD_COUNT <= '0;
                out_ERROR      <= 1'b0;
                out_CPU_RST    <= 1'b1;
            end else begin
                if (rx_acc) begin
                    idx <= idx + 2'd1;
                    tmo <= '0;
                    case (idx)
                        2'd0:    asm_q[7:0]   <= in_RX_DATA;
                        2'd1:    asm_q[15:8]  <= in_RX_DATA;
                        2'd2:    asm_q[23:16] <= in_RX_DATA;
                        default: ;
                    endcase
                end else if (state == RECV) begin
                    tmo <= tmo + 1'b1;
                end
                // Write lands one cycle after the 4th byte; count advances with it.
                if (word_done && !is_stop && !mem_full) begin
                    out_MEM_WE     <= 1'b1;
                    out_MEM_ADDR   <= out_WORD_COUNT[ADDR_WIDTH-1:0];
                    out_MEM_WDATA  <= word;
                    out_WORD_COUNT <= out_WORD_COUNT + 1'b1;
                end
                if ((word_done && !is_stop && mem_full) || tmo_hit) out_ERROR <= 1'b1;
                if (state == ACK_CR && in_TX_READY) begin
                    out_CPU_RST <= 1'b0;
                    out_DONE    <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_uart_boot_loader.sv
// Directed bench for uart_boot_loader with a 4-word memory and a short RX timeout.
module tb_uart_boot_loader;
    localparam int AW  = 2;
    localparam int TMO = 40;

    logic          in_CLK, in_RST_N, in_FLASH, in_RX_VALID, in_TX_READY;
    logic [7:0]    in_RX_DATA;
    logic [7:0]    out_TX_DATA;
    logic          out_TX_VALID, out_MEM_WE, out_CPU_RST, out_BUSY, out_DONE, out_ERROR;
    logic [AW-1:0] out_MEM_ADDR;
    logic [31:0]   out_MEM_WDATA;
    logic [AW:0]   out_WORD_COUNT;

    uart_boot_loader #(.ADDR_WIDTH(AW), .STOP_WORD(32'hFFFF_FFFF), .TIMEOUT_CYCLES(TMO)) u_dut (
        .in_CLK(in_CLK), .in_RST_N(in_RST_N), .in_FLASH(in_FLASH),
        .in_RX_DATA(in_RX_DATA), .in_RX_VALID(in_RX_VALID),
        .out_TX_DATA(out_TX_DATA), .out_TX_VALID(out_TX_VALID), .in_TX_READY(in_TX_READY),
        .out_MEM_WE(out_MEM_WE), .out_MEM_ADDR(out_MEM_ADDR), .out_MEM_WDATA(out_MEM_WDATA),
        .out_CPU_RST(out_CPU_RST), .out_BUSY(out_BUSY), .out_DONE(out_DONE),
        .out_ERROR(out_ERROR), .out_WORD_COUNT(out_WORD_COUNT)
    );

    initial begin
        in_CLK = 1'b0;
        forever #5 in_CLK = ~in_CLK;
    end

    // Monitor: logs writes, TX handshakes, DONE pulses and CPU-reset gaps while busy.
    logic [AW+31:0] wr_q[$];
    logic [7:0]     tx_q[$];
    int             done_cnt = 0;
    int             rst_bad  = 0;
    logic           rst_at_done = 1'b1;

    always @(negedge in_CLK) begin
        if (out_MEM_WE) wr_q.push_back({out_MEM_ADDR, out_MEM_WDATA});
        if (out_TX_VALID && in_TX_READY) tx_q.push_back(out_TX_DATA);
        if (out_DONE) begin
            done_cnt++;
            rst_at_done = out_CPU_RST;
        end
        if (out_BUSY && !out_CPU_RST) rst_bad++;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic flash();
        @(posedge in_CLK); #1 in_FLASH = 1'b1;
        @(posedge in_CLK); #1 in_FLASH = 1'b0;
    endtask

    // Bytes go out back to back; rx_off drops the strobe after the last one.
    task automatic send_byte(input logic [7:0] b);
        @(posedge in_CLK); #1 in_RX_DATA = b; in_RX_VALID = 1'b1;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
    endtask

    task automatic rx_off();
        @(posedge in_CLK); #1 in_RX_VALID = 1'b0;
    endtask

    task automatic wait_done(input int base);
        int n = 0;
        while (done_cnt == base && n < 300) begin
            @(negedge in_CLK);
            n++;
        end
        if (done_cnt == base) chk("done_wait_expired", 64'd0, 64'd1);
    endtask

    logic [31:0] w4[4] = '{32'h0000FF08, 32'h00000209, 32'h00002042, 32'h00000C90};
    logic [31:0] w5[5] = '{32'h00000001, 32'h12345678, 32'hFFFFFF00, 32'h00FFFFFF, 32'hDEADBEEF};
    int wb, tb, db, rb;

    initial begin
        in_RST_N = 1'b0; in_FLASH = 1'b0; in_RX_VALID = 1'b0; in_RX_DATA = 8'h00; in_TX_READY = 1'b1;
        repeat (3) @(negedge in_CLK);
        chk("reset_outs", {out_BUSY, out_CPU_RST, out_ERROR, out_TX_VALID, out_MEM_WE, out_DONE, out_TX_DATA}, 64'd0);
        chk("reset_wc", out_WORD_COUNT, 64'd0);
        @(posedge in_CLK); #1 in_RST_N = 1'b1;

        // Four words then stop
        wb = wr_q.size(); tb = tx_q.size(); db = done_cnt; rb = rst_bad;
        flash();
        @(negedge in_CLK);
        chk("start_cpu_rst", {out_CPU_RST, out_BUSY}, 64'h3);
        for (int i = 0; i < 4; i++) send_word(w4[i]);
        send_word(32'hFFFFFFFF);
        rx_off();
        wait_done(db);
        chk("main_nwr", wr_q.size() - wb, 64'd4);
        for (int i = 0; i < 4; i++) chk("main_wr", wr_q[wb+i], {AW'(i), w4[i]});
        chk("main_ntx", tx_q.size() - tb, 64'd2);
        chk("main_tx0", tx_q[tb], 64'h52);
        chk("main_tx1", tx_q[tb+1], 64'h0D);
        chk("main_done", done_cnt - db, 64'd1);
        chk("main_wc", out_WORD_COUNT, 64'd4);
        chk("main_rst_held", rst_bad - rb, 64'd0);
        chk("main_rst_at_done", rst_at_done, 64'd0);
        @(negedge in_CLK);
        chk("main_after", {out_CPU_RST, out_BUSY, out_DONE, out_ERROR}, 64'd0);

        // Stop word only
        wb = wr_q.size(); tb = tx_q.size(); db = done_cnt;
        flash();
        send_word(32'hFFFFFFFF);
        rx_off();
        wait_done(db);
        chk("stop_nwr", wr_q.size() - wb, 64'd0);
        chk("stop_ntx", tx_q.size() - tb, 64'd2);
        chk("stop_tx", {tx_q[tb], tx_q[tb+1]}, 64'h520D);
        chk("stop_wc", out_WORD_COUNT, 64'd0);
        chk("stop_done", done_cnt - db, 64'd1);

        // Timeout after two bytes
        wb = wr_q.size(); tb = tx_q.size();
        flash();
        send_byte(8'h08); send_byte(8'hFF);
        rx_off();
        repeat (35) @(negedge in_CLK);
        chk("tmo_early", {out_BUSY, out_ERROR}, 64'h2);
        repeat (10) @(negedge in_CLK);
        chk("tmo_err", {out_ERROR, out_CPU_RST, out_BUSY, out_TX_VALID}, 64'hC);
        chk("tmo_nwr", wr_q.size() - wb, 64'd0);
        chk("tmo_ntx", tx_q.size() - tb, 64'd0);
        flash();
        @(negedge in_CLK);
        chk("tmo_restart", {out_ERROR, out_BUSY, out_CPU_RST}, 64'h3);

        // Memory full on the fifth word
        wb = wr_q.size(); tb = tx_q.size();
        flash();
        for (int i = 0; i < 5; i++) send_word(w5[i]);
        rx_off();
        repeat (3) @(negedge in_CLK);
        chk("full_nwr", wr_q.size() - wb, 64'd4);
        for (int i = 0; i < 4; i++) chk("full_wr", wr_q[wb+i], {AW'(i), w5[i]});
        chk("full_err", {out_ERROR, out_BUSY, out_CPU_RST}, 64'h5);
        chk("full_wc", out_WORD_COUNT, 64'd4);
        chk("full_ntx", tx_q.size() - tb, 64'd0);

        // TX back-pressure in ACK_R
        tb = tx_q.size(); db = done_cnt;
        flash();
        in_TX_READY = 1'b0;
        send_word(32'hFFFFFFFF);
        rx_off();
        for (int i = 0; i < 50; i++) begin
            @(negedge in_CLK);
            chk("stall_hold", {out_TX_VALID, out_TX_DATA}, {1'b1, 8'h52});
        end
        @(posedge in_CLK); #1 in_TX_READY = 1'b1;
        wait_done(db);
        chk("stall_ntx", tx_q.size() - tb, 64'd2);
        chk("stall_tx", {tx_q[tb], tx_q[tb+1]}, 64'h520D);
        chk("stall_done", done_cnt - db, 64'd1);

        // Restart after two words
        wb = wr_q.size(); db = done_cnt;
        flash();
        send_word(32'hA1A2A3A4); send_word(32'hB1B2B3B4);
        rx_off();
        flash();
        send_word(32'hC1C2C3C4); send_word(32'hFFFFFFFF);
        rx_off();
        wait_done(db);
        chk("mid_nwr", wr_q.size() - wb, 64'd3);
        chk("mid_wr2", wr_q[wb+2], {2'd0, 32'hC1C2C3C4});
        chk("mid_wc", out_WORD_COUNT, 64'd1);

        // Async reset in the middle of a word
        tb = tx_q.size();
        flash();
        send_word(32'h01020304);
        send_byte(8'hAA); send_byte(8'hBB);
        #2 in_RST_N = 1'b0; in_RX_VALID = 1'b0;
        #1;
        chk("arst_outs", {out_BUSY, out_CPU_RST, out_ERROR, out_TX_VALID, out_MEM_WE, out_DONE}, 64'd0);
        chk("arst_wc", out_WORD_COUNT, 64'd0);
        @(posedge in_CLK); #1 in_RST_N = 1'b1;
        send_word(32'hFFFFFFFF);
        rx_off();
        repeat (5) @(negedge in_CLK);
        chk("arst_idle", {out_BUSY, out_TX_VALID}, 64'd0);
        chk("arst_ntx", tx_q.size() - tb, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/uart_boot_loader.md
Name: uart_boot_loader

Overview:
- Sequences program loading into CPU instruction memory from the UART receive byte stream.
- On a flash request, it holds the CPU in reset and assembles 32-bit little-endian words from received bytes.
- Each word is written to consecutive instruction-memory addresses. Loading terminates on the stop word.
- On success it sends "R",CR over the UART transmit handshake and releases the CPU.

Parameters:
- ADDR_WIDTH, 8: instruction memory word-address width; capacity is 2**ADDR_WIDTH words.
- STOP_WORD, 32'hFFFF_FFFF: terminator word; it is never written to memory.
- TIMEOUT_CYCLES, 2000000: maximum in_CLK cycles allowed between bytes while loading.

Ports:
- in_CLK  in  1  system clock.
- in_RST_N  in  1  asynchronous active-low reset.
- in_FLASH  in  1  load request; only its rising edge is used.
- in_RX_DATA  in  8  received byte; valid when in_RX_VALID=1.
- in_RX_VALID  in  1  one-cycle strobe, one per received byte.
- out_TX_DATA  out  8  byte to transmit.
- out_TX_VALID  out  1  transmit request; held until accepted.
- in_TX_READY  in  1  transmitter accepts the byte when out_TX_VALID & in_TX_READY.
- out_MEM_WE  out  1  instruction memory write enable, one-cycle pulse.
- out_MEM_ADDR  out  ADDR_WIDTH  write word address.
- out_MEM_WDATA  out  32  write data.
- out_CPU_RST  out  1  CPU reset hold, active-high.
- out_BUSY  out  1  high in every state except IDLE and ERR.
- out_DONE  out  1  one-cycle pulse on successful load.
- out_ERROR  out  1  sticky error flag; cleared by the next flash start.
- out_WORD_COUNT  out  ADDR_WIDTH+1  number of words written in the current or last load.

Behaviour:
- Reset (async, in_RST_N=0):
  - State IDLE; all outputs 0, including out_CPU_RST=0.
  - Byte index, word counter, timeout counter and the registered in_FLASH are cleared.
- Flash edge: in_FLASH is registered once; start = in_FLASH & ~flash_q.
  - Start in any state clears the byte index, word count, timeout counter and out_ERROR.
  - It sets out_CPU_RST=1 and enters RECV.
  - Start mid-load or mid-ACK restarts from address 0 and drops any pending TX byte.
- States: IDLE, RECV, ACK_R, ACK_CR, ERR.
- RECV, byte assembly:
  - Each in_RX_VALID places in_RX_DATA at bits [8*idx+7:8*idx] of the assembly register; idx wraps 0..3. The first byte received is the LSB.
  - The timeout counter clears on every in_RX_VALID.
- RECV, word completion (byte with idx=3):
  - Word==STOP_WORD: go to ACK_R; no memory write.
  - Else if word count == 2**ADDR_WIDTH: go to ERR (memory full).
  - Else, on the next cycle: out_MEM_WE=1, out_MEM_ADDR=word count[ADDR_WIDTH-1:0], out_MEM_WDATA=word. Word count increments in that same cycle.
  - Write latency is exactly 1 cycle after the 4th byte strobe.
  - A byte arriving in the write cycle is accepted as byte 0 of the next word; no byte is ever dropped.
- RECV, timeout: if the timeout counter reaches TIMEOUT_CYCLES-1 with no in_RX_VALID, go to ERR. This applies regardless of idx.
- ACK_R: out_TX_DATA=8'h52, out_TX_VALID=1 until in_TX_READY=1, then ACK_CR.
- ACK_CR: out_TX_DATA=8'h0D, out_TX_VALID=1 until in_TX_READY=1. Then:
  - out_CPU_RST=0 and out_DONE=1 for one cycle, registered on the handshake cycle +1.
  - Return to IDLE.
- Handshake rules:
  - out_TX_DATA must be stable while out_TX_VALID=1.
  - in_RX_VALID is ignored in ACK_R, ACK_CR, IDLE and ERR.
- ERR: out_ERROR=1, out_CPU_RST stays 1, no TX, no memory writes. Only start or reset leaves ERR.
- out_WORD_COUNT holds its final value in IDLE and ERR until the next start.
- A stop word as the first word is legal: zero writes, ACK, DONE.
- A partial stop pattern (e.g. FF FF FF 00) is an ordinary word and is written.

Test Plan:
- Load 16 bytes 08 FF 00 00, 09 02 00 00, 42 20 00 00, 90 0C 00 00, then FF FF FF FF. Required response:
  - Writes (0,0x0000FF08), (1,0x00000209), (2,0x00002042), (3,0x00000C90).
  - TX 0x52 then 0x0D; out_DONE pulse; out_WORD_COUNT=4; out_CPU_RST high from start until the pulse.
- Stop word only: zero out_MEM_WE pulses, TX "R",CR, out_WORD_COUNT=0, out_DONE=1.
- Bytes 08 FF then silence for TIMEOUT_CYCLES. Required response:
  - ERR state, out_ERROR=1, out_CPU_RST=1, no write, no TX.
  - A new in_FLASH edge clears out_ERROR and returns to RECV.
- ADDR_WIDTH=2: send 5 non-stop words. Required response:
  - Writes at addresses 0..3.
  - The 5th word completion gives out_ERROR=1 and out_WORD_COUNT=4.
- Hold in_TX_READY=0 for 50 cycles in ACK_R. Required response:
  - out_TX_VALID=1 and out_TX_DATA=0x52 stable throughout.
  - Release gives 0x0D next; back-to-back ready gives exactly 2 bytes.
- Mid-load in_FLASH edge after 2 words, then 1 word + stop: third write at address 0, out_WORD_COUNT=1.
- Assert in_RST_N low mid-word: outputs 0 immediately, state IDLE, word count 0.
